// File: rtl/tmr_pkg.sv
// tmr_pkg: lane select and injector state encodings for the TMR fanout injector
package tmr_pkg;
  typedef enum logic [1:0] {LANE_A = 2'd0, LANE_B = 2'd1, LANE_C = 2'd2, LANE_ALL = 2'd3} lane_e;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACTIVE = 2'd2} inj_state_e;
endpackage

// File: rtl/tmr_inj_fsm.sv
// tmr_inj_fsm: injection handshake (req in, one-cycle ack out), delay/length counting, captures lane select and mask
module tmr_inj_fsm
  import tmr_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [1:0]       lane,
  input  logic [WIDTH-1:0] mask,
  input  logic [DLY_W-1:0] delay,
  input  logic [DLY_W-1:0] len,
  output logic             active,
  output lane_e            sel,
  output logic [WIDTH-1:0] mask_q,
  output logic             ack,
  output logic             busy
);
  inj_state_e       state, nstate;
  logic [DLY_W-1:0] cnt, ncnt, len_q;
  logic [DLY_W-1:0] len_eff;
  logic             accept;
  assign len_eff = (len == '0) ? DLY_W'(1) : len;
  assign accept  = (state == IDLE) && req;
  assign active  = (state == ACTIVE);
  assign busy    = (state != IDLE);
  always_comb begin
    nstate = state;
    ncnt   = cnt - DLY_W'(1);
    if (state == IDLE) begin
      nstate = !req ? IDLE : ((delay == '0) ? ACTIVE : WAIT);
      ncnt   = (delay == '0) ? len_eff : delay;
    end else if (cnt == DLY_W'(1)) begin
      nstate = (state == WAIT) ? ACTIVE : IDLE;
      ncnt   = len_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      len_q  <= '0;
      sel    <= LANE_A;
      mask_q <= '0;
      ack    <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      ack   <= accept;
      if (accept) begin
        sel    <= lane_e'(lane);
        mask_q <= mask;
        len_q  <= len_eff;
      end
    end
  end
endmodule

// File: rtl/tmr_fanout_injector.sv
// tmr_fanout_injector: golden register fanned to lanes a/b/c with XOR fault injection, plus voter-result mismatch monitor (cnt, sticky)
module tmr_fanout_injector
  import tmr_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int DLY_W     = 8,
  parameter int CNT_W     = 16,
  parameter int VOTER_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  output logic [WIDTH-1:0] lane_a,
  output logic [WIDTH-1:0] lane_b,
  output logic [WIDTH-1:0] lane_c,
  input  logic             inj_req,
  input  logic [1:0]       inj_lane,
  input  logic [WIDTH-1:0] inj_mask,
  input  logic [DLY_W-1:0] inj_delay,
  input  logic [DLY_W-1:0] inj_len,
  output logic             inj_ack,
  output logic             inj_busy,
  output logic             inj_active,
  input  logic [WIDTH-1:0] voted_in,
  input  logic             mon_en,
  input  logic             clr,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             mismatch_sticky
);
  logic [WIDTH-1:0]                golden, mask_q;
  logic [VOTER_LAT-1:0][WIDTH-1:0] pipe;
  lane_e                           sel;
  tmr_inj_fsm #(.WIDTH(WIDTH), .DLY_W(DLY_W)) u_fsm (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (inj_req),
    .lane   (inj_lane),
    .mask   (inj_mask),
    .delay  (inj_delay),
    .len    (inj_len),
    .active (inj_active),
    .sel    (sel),
    .mask_q (mask_q),
    .ack    (inj_ack),
    .busy   (inj_busy)
  );
  assign lane_a = golden ^ ((inj_active && (sel == LANE_A || sel == LANE_ALL)) ? mask_q : '0);
  assign lane_b = golden ^ ((inj_active && (sel == LANE_B || sel == LANE_ALL)) ? mask_q : '0);
  assign lane_c = golden ^ ((inj_active && (sel == LANE_C || sel == LANE_ALL)) ? mask_q : '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      golden          <= '0;
      pipe            <= '0;
      mismatch_cnt    <= '0;
      mismatch_sticky <= 1'b0;
    end else begin
      if (d_valid) golden <= d_in;
      pipe[0] <= golden;
      for (int i = 1; i < VOTER_LAT; i++) pipe[i] <= pipe[i-1];
      if (clr) begin
        mismatch_cnt    <= '0;
        mismatch_sticky <= 1'b0;
      end else if (mon_en && voted_in != pipe[VOTER_LAT-1]) begin
        mismatch_cnt    <= (mismatch_cnt == '1) ? mismatch_cnt : mismatch_cnt + CNT_W'(1);
        mismatch_sticky <= 1'b1;
      end
    end
  end
endmodule
